// File: rtl/alu_pkg.sv
// Shared definitions for the ALU divider slice.
//
// Contents:
//   DATA_WIDTH     default operand/result width
//   DIV_ZERO_QUOT  quotient returned for a zero divisor (all ones)
//   div_op_e       M-extension divide op encoding (DIV, DIVU, REM, REMU)
//   div_state_e    iterative divider FSM states (IDLE, ITER, FINAL)
package alu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  // Bit 0 set = unsigned, bit 1 set = remainder.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ITER  = 2'b01,
    FINAL = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring compare-subtract-shift iteration, purely combinational.
//
// Ports:
//   rem           partial remainder entering this iteration
//   dividend_msb  next dividend bit, shifted into the remainder LSB
//   divisor       divisor magnitude
//   rem_out       partial remainder leaving this iteration
//   q_bit         quotient bit produced (1 = subtract taken)
module div_step
  import alu_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic [data_width-1:0] rem,
  input  logic                  dividend_msb,
  input  logic [data_width-1:0] divisor,
  output logic [data_width-1:0] rem_out,
  output logic                  q_bit
);

  logic [data_width:0] rem_next;
  logic [data_width:0] diff;

  assign rem_next = {rem, dividend_msb};

  // Because rem < divisor on entry, rem_next < 2*divisor, so a
  // (data_width+1)-bit difference has an unambiguous sign bit and a
  // non-negative difference always fits in data_width bits. With a zero
  // divisor the invariant breaks, but the quotient is overridden later and
  // the remainder still just shifts in the dividend bits.
  assign diff    = rem_next - {1'b0, divisor};
  assign q_bit   = ~diff[data_width];
  assign rem_out = q_bit ? diff[data_width-1:0] : rem_next[data_width-1:0];

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider for RV32IM DIV/DIVU/REM/REMU.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request, sampled only while busy=0
//   div_op     00=DIV 01=DIVU 10=REM 11=REMU
//   operand_A  dividend, captured with start
//   operand_B  divisor, captured with start
//   busy       operation in progress
//   valid      one-cycle pulse, result is new
//   result     quotient or remainder, held until the next valid
//   state_dbg  current FSM state
//
// Optional build macro DIV_EARLY_OUT_EN: zero divisor, signed overflow and
// zero dividend skip ITER and go straight from IDLE to FINAL.
//
// Handshake: start is accepted on a rising edge where busy=0 and start=1;
// busy rises from that edge and stays high until the edge that raises valid.
// valid is high for exactly one cycle, during which busy=0, so a new start in
// the valid cycle is accepted. start while busy=1 is ignored.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            div_op,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  output logic                  busy,
  output logic                  valid,
  output logic [data_width-1:0] result,
  output div_state_e            state_dbg
);

  localparam int CNT_W = (data_width > 1) ? $clog2(data_width) : 1;

  div_state_e state, state_next;

  // Operation context captured at acceptance.
  logic op_rem_q, sign_a_q, sign_b_q, b_zero_q;
  logic [data_width-1:0] quot_q;     // dividend shifts out MSB-first, quotient shifts in
  logic [data_width-1:0] divisor_q;
  logic [data_width-1:0] rem_q;
  logic [CNT_W-1:0]      count_q;

  // Acceptance-time decode.
  logic                  in_signed, in_sign_a, in_sign_b, in_b_zero;
  logic [data_width-1:0] abs_a, abs_b;
  logic                  early_out;

  // Iteration and finalisation.
  logic [data_width-1:0] rem_step;
  logic                  q_bit;
  logic                  last_iter;
  logic [data_width-1:0] final_quot, final_rem;

  assign in_signed = ~div_op[0];
  assign in_sign_a = in_signed & operand_A[data_width-1];
  assign in_sign_b = in_signed & operand_B[data_width-1];
  assign abs_a     = in_sign_a ? -operand_A : operand_A;
  assign abs_b     = in_sign_b ? -operand_B : operand_B;
  assign in_b_zero = (operand_B == '0);

`ifdef DIV_EARLY_OUT_EN
  logic in_a_zero, in_ovf;
  assign in_a_zero = (operand_A == '0);
  assign in_ovf    = in_signed && (operand_A == {1'b1, {(data_width-1){1'b0}}})
                     && (&operand_B);
  assign early_out = in_b_zero | in_a_zero | in_ovf;
`else
  assign early_out = 1'b0;
`endif

  div_step #(.data_width(data_width)) u_step (
    .rem          (rem_q),
    .dividend_msb (quot_q[data_width-1]),
    .divisor      (divisor_q),
    .rem_out      (rem_step),
    .q_bit        (q_bit)
  );

  assign last_iter = (count_q == CNT_W'(data_width - 1));

  // Sign correction. Zero dividend and signed overflow need no special case:
  // on the early-out path quot_q still holds |A| (0 or 0x80..0), rem_q is 0,
  // and the sign rules leave those values as the required results.
  // A zero divisor forces the quotient; its remainder comes out of the sign
  // rule because rem_q holds |A| on both paths.
  assign final_quot = b_zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quot_q : quot_q);
  assign final_rem  = sign_a_q ? -rem_q : rem_q;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = early_out ? FINAL : ITER;
      ITER:    if (last_iter) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rem_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      quot_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      result    <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_rem_q  <= div_op[1];
            sign_a_q  <= in_sign_a;
            sign_b_q  <= in_sign_b;
            b_zero_q  <= in_b_zero;
            quot_q    <= abs_a;
            divisor_q <= abs_b;
            // Early-out on a zero divisor skips the shifts that would have
            // moved |A| into the remainder, so preload it.
            rem_q     <= (early_out && in_b_zero) ? abs_a : '0;
            count_q   <= '0;
          end
        end
        ITER: begin
          rem_q   <= rem_step;
          quot_q  <= {quot_q[data_width-2:0], q_bit};
          count_q <= count_q + CNT_W'(1);
        end
        FINAL: begin
          result <= op_rem_q ? final_rem : final_quot;
          valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
module tb_alu_div_seq;
  import alu_pkg::*;

  localparam int W      = 32;
  localparam int PERIOD = 10;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   div_op = 2'b00;
  logic [W-1:0] operand_A = '0;
  logic [W-1:0] operand_B = '0;
  logic         busy, valid;
  logic [W-1:0] result;
  div_state_e   state_dbg;

  always #(PERIOD/2) clk = ~clk;

  alu_div_seq #(.data_width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .div_op    (div_op),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] last_res = '0;
  logic         prev_valid = 1'b0;
  logic         hold_bad = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic   is_signed, is_rem;
    is_signed = (op == OP_DIV) || (op == OP_REM);
    is_rem    = (op == OP_REM) || (op == OP_REMU);
    if (b == '0) return is_rem ? a : DIV_ZERO_QUOT;
    if (is_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;   // truncates toward zero, remainder takes dividend sign
    r = sa % sb;
    return is_rem ? r[W-1:0] : q[W-1:0];
  endfunction

  // Rising edges after the accepting edge until valid is visible.
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    int lat;
    lat = 33;
`ifdef DIV_EARLY_OUT_EN
    if (b == '0 || a == '0 ||
        ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      lat = 1;
`else
    if (op == 2'b00 && a == b && a != a) lat = 0;  // keeps args referenced; never true
`endif
    return lat;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", result, ~result);
        end else begin
          check(name_q.pop_front(), result, exp_q.pop_front());
        end
        check("valid_pulse_width", {31'd0, prev_valid}, '0);
        check("result_hold", {31'd0, hold_bad}, '0);
        hold_bad = 1'b0;
        last_res = result;
      end else if (result !== last_res) begin
        hold_bad = 1'b1;
      end
    end
    prev_valid = valid;
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge of the valid cycle.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat_exp, input string nm,
                       input bit intrude);
    int lat;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    start = 1'b1; div_op = op; operand_A = a; operand_B = b;
    @(negedge clk);
    start = 1'b0;
    operand_A = $urandom; operand_B = $urandom; div_op = 2'($urandom_range(0, 3));
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (intrude && lat == 4) begin
        start = 1'b1; div_op = OP_DIVU; operand_A = 32'd9; operand_B = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({nm, "_latency"}, W'(lat), W'(lat_exp));
    check({nm, "_busy_at_valid"}, {31'd0, busy}, '0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    string        nm;
  } vec_t;

  vec_t vecs[15];

  initial begin
    time t1, t2;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{OP_DIVU, 32'd100,         32'd7,           32'd14,          "divu_100_7"};
    vecs[1]  = '{OP_REMU, 32'd100,         32'd7,           32'd2,           "remu_100_7"};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   "div_m7_2"};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   "rem_m7_2"};
    vecs[4]  = '{OP_REM,  32'd7,           32'hFFFF_FFFE,   32'd1,           "rem_7_m2"};
    vecs[5]  = '{OP_DIV,  32'hFFFF_FFF9,   32'hFFFF_FFFE,   32'd3,           "div_m7_m2"};
    vecs[6]  = '{OP_DIV,  32'd5,           32'd0,           32'hFFFF_FFFF,   "div_5_0"};
    vecs[7]  = '{OP_REM,  32'hFFFF_FFFB,   32'd0,           32'hFFFF_FFFB,   "rem_m5_0"};
    vecs[8]  = '{OP_DIVU, 32'd5,           32'd0,           32'hFFFF_FFFF,   "divu_5_0"};
    vecs[9]  = '{OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   "div_ovf"};
    vecs[10] = '{OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           "rem_ovf"};
    vecs[11] = '{OP_REMU, 32'hFFFF_FFFF,   32'd16,          32'd15,          "remu_max_16"};
    vecs[12] = '{OP_DIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   "divu_max_1"};
    vecs[13] = '{OP_DIV,  32'd0,           32'd5,           32'd0,           "div_0_5"};
    vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,   32'hFFFF_FFFE,   32'd1,           "divu_max_maxm1"};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, busy},  '0);
    check("reset_valid",  {31'd0, valid}, '0);
    check("reset_result", result,         '0);
    check("reset_state",  W'(state_dbg),  W'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // directed table
    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
            exp_lat(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].nm, 1'b0);

    // back-to-back: start in the valid cycle
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "b2b_first", 1'b0);
    t1 = $time;
    do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, "b2b_second", 1'b0);
    t2 = $time;
    check("b2b_throughput", W'((t2 - t1) / PERIOD), 32'd34);

    // start while busy is ignored
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "ignore_start", 1'b1);
    repeat (40) @(negedge clk);
    check("ignore_start_no_extra", W'(exp_q.size()), '0);

    // asynchronous reset mid-operation
    start = 1'b1; div_op = OP_DIVU; operand_A = 32'd1000; operand_B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   {31'd0, busy},  '0);
    check("arst_valid",  {31'd0, valid}, '0);
    check("arst_result", result,         '0);
    check("arst_state",  W'(state_dbg),  W'(IDLE));
    last_res = '0;
    hold_bad = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_no_valid", W'(exp_q.size()), '0);
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, "after_arst", 1'b0);

    // randomized against the reference model
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      do_op(rop, ra, rb, ref_model(rop, ra, rb), exp_lat(rop, ra, rb), "random", 1'b0);
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
